// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: mult/div FSM state encoding and counter width.
// Pure declarations; no latency or backpressure of its own.
package pipe_hazard_ctrl_pkg;

    localparam int MD_CNT_W = 8;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } md_state_e;

    function automatic logic [MD_CNT_W-1:0] md_cycles(input logic is_div,
                                                      input int   mult_cycles,
                                                      input int   div_cycles);
        return is_div ? MD_CNT_W'(div_cycles) : MD_CNT_W'(mult_cycles);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use hazard detect between the load in EX and the instruction in ID.
// Purely combinational, zero latency; no backpressure of its own.
module load_use_detect (
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       ifid_uses_rt,
    output logic       hazard
);

    // r0 is hardwired zero, so a load into it never creates a dependency.
    assign hazard = idex_mem_read && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: load-use bubbles, branch flushes, multi-cycle mult/div stalls.
// Enables/flushes are same-cycle combinational; md_done and stall_cnt are registered.
module pipe_hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        idex_mem_read,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        ifid_uses_rt,
    input  logic        branch_taken,
    input  logic        md_start,
    input  logic        md_is_div,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [15:0] stall_cnt
);
    import pipe_hazard_ctrl_pkg::*;

    md_state_e             state;
    logic [MD_CNT_W-1:0]   md_cnt;
    logic [MD_CNT_W-1:0]   md_n;
    logic                  md_done_q;
    logic [15:0]           stall_cnt_q;
    logic                  rearm;
    logic                  hazard;
    logic                  md_fire;
    logic                  md_stall;

    load_use_detect u_load_use_detect (
        .idex_mem_read (idex_mem_read),
        .idex_rt       (idex_rt),
        .ifid_rs       (ifid_rs),
        .ifid_rt       (ifid_rt),
        .ifid_uses_rt  (ifid_uses_rt),
        .hazard        (hazard)
    );

    assign md_n     = md_cycles(md_is_div, MULT_CYCLES, DIV_CYCLES);
    // A held md_start must drop for a cycle before it can launch another op.
    assign md_fire  = !rst && (state == RUN) && md_start && rearm;
    assign md_stall = md_fire || (!rst && (state == MD_WAIT));

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        md_busy     = 1'b0;
        if (rst) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (md_stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
            md_busy     = 1'b1;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (hazard) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            md_cnt      <= '0;
            md_done_q   <= 1'b0;
            stall_cnt_q <= '0;
            rearm       <= 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (md_fire) begin
                        md_cnt <= md_n - MD_CNT_W'(1);
                        state  <= (md_n > MD_CNT_W'(1)) ? MD_WAIT : RUN;
                    end
                end
                MD_WAIT: begin
                    md_cnt <= md_cnt - MD_CNT_W'(1);
                    if (md_cnt == MD_CNT_W'(1)) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase

            md_done_q <= (md_fire && (md_n == MD_CNT_W'(1))) ||
                         ((state == MD_WAIT) && (md_cnt == MD_CNT_W'(1)));

            if (md_fire) begin
                rearm <= 1'b0;
            end else if (!md_start) begin
                rearm <= 1'b1;
            end

            if (!pc_en && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    // Registered values are masked so reset reads as zero from its first cycle.
    assign md_done   = md_done_q && !rst;
    assign stall_cnt = rst ? 16'd0 : stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a cycle-indexed reference model.
module tb_pipe_hazard_ctrl;

    localparam int MULT_N = 4;
    localparam int DIV_N  = 32;

    logic        clk = 1'b0;
    logic        rst, idex_mem_read, ifid_uses_rt, branch_taken, md_start, md_is_div;
    logic [4:0]  idex_rt, ifid_rs, ifid_rt;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, md_busy, md_done;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: an operation started at cycle s occupies cycles s..s+N-1, done at s+N.
    int cyc_n    = 0;
    int op_end   = -1;
    bit seen_low = 1'b1;
    int stall_m  = 0;
    bit held_div = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .rst(rst),
        .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .branch_taken(branch_taken), .md_start(md_start), .md_is_div(md_is_div),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    // Flag order: pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem flushes, busy.
    task automatic step(input logic r, input logic mr, input logic [4:0] irt,
                        input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic bt, input logic ms, input logic mdiv);
        logic [8:0]  exp_f;
        logic        exp_done;
        logic [15:0] exp_cnt;
        bit          busy_prev, start, hz;
        int          n;
        @(negedge clk);
        rst = r; idex_mem_read = mr; idex_rt = irt; ifid_rs = rs; ifid_rt = rt;
        ifid_uses_rt = urt; branch_taken = bt; md_start = ms; md_is_div = mdiv;
        #1;
        n         = mdiv ? DIV_N : MULT_N;
        busy_prev = (op_end > cyc_n);
        start     = 1'b0;
        if (r) begin
            exp_f = 9'b0; exp_done = 1'b0; exp_cnt = 16'd0;
        end else begin
            start = !busy_prev && ms && seen_low;
            hz    = mr && (irt != 0) && ((irt == rs) || (urt && (irt == rt)));
            if (start || busy_prev) exp_f = 9'b000110011;
            else if (bt)            exp_f = 9'b111111100;
            else if (hz)            exp_f = 9'b001110100;
            else                    exp_f = 9'b111110000;
            exp_done = (cyc_n == op_end);
            exp_cnt  = 16'(stall_m);
        end
        chk("flags", {23'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                      ifid_flush, idex_flush, exmem_flush, md_busy}, {23'd0, exp_f});
        chk("md_done", {31'd0, md_done}, {31'd0, exp_done});
        chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, exp_cnt});
        if (r) begin
            op_end = -1; seen_low = 1'b1; stall_m = 0;
        end else begin
            if (start) op_end = cyc_n + n;
            if (!ms) seen_low = 1'b1;
            if (start) seen_low = 1'b0;
            if (!exp_f[8] && stall_m < 65535) stall_m++;
        end
        cyc_n++;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int stalls;
        int done_at;
        bit b_mr, b_urt, b_bt, b_ms, b_div;
        logic [4:0] v_irt, v_rs, v_rt;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 5, 5, 0, 0, 1, 1, 0);
        chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
        chk("rst_cnt", {16'd0, stall_cnt}, 32'd0);

        // Load r5 followed by a reader of r5: exactly one bubble.
        step(0, 1, 5, 5, 0, 0, 0, 0, 0);
        chk("lu_pc_en", {31'd0, pc_en}, 32'd0);
        chk("lu_idex_flush", {31'd0, idex_flush}, 32'd1);
        idle();
        chk("lu_cnt", {16'd0, stall_cnt}, 32'd1);

        // Load into r0 never stalls.
        step(0, 1, 0, 0, 0, 1, 0, 0, 0);
        chk("r0_pc_en", {31'd0, pc_en}, 32'd1);

        // Branch overrides a simultaneous load-use.
        step(0, 1, 7, 3, 7, 1, 1, 0, 0);
        chk("br_pc_en", {31'd0, pc_en}, 32'd1);
        chk("br_flush", {30'd0, ifid_flush, idex_flush}, 32'd3);

        // Held multiply: 4 stall cycles, done in the fifth, no relaunch.
        stalls = 0; done_at = -1;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 1, 0);
            if (!pc_en) stalls++;
            if (md_done) done_at = i;
        end
        chk("mult_stalls", stalls, MULT_N);
        chk("mult_done_at", done_at, MULT_N);
        idle();

        // Divide aborted by reset at stall cycle 10.
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("abort_busy", {31'd0, md_busy}, 32'd0);
        chk("abort_cnt", {16'd0, stall_cnt}, 32'd0);
        idle();
        chk("abort_run_pc", {31'd0, pc_en}, 32'd1);
        chk("abort_run_busy", {31'd0, md_busy}, 32'd0);

        // Random traffic; mult/div inputs stay held while an op is in flight.
        for (int i = 0; i < 4000; i++) begin
            b_mr  = ($urandom_range(0, 1) == 1);
            v_irt = 5'($urandom_range(0, 3));
            v_rs  = 5'($urandom_range(0, 3));
            v_rt  = 5'($urandom_range(0, 3));
            b_urt = ($urandom_range(0, 1) == 1);
            b_bt  = ($urandom_range(0, 3) == 0);
            if (op_end > cyc_n) begin
                b_ms = 1'b1; b_div = held_div;
            end else begin
                b_ms  = ($urandom_range(0, 5) == 0) || (op_end == cyc_n && $urandom_range(0, 1) == 1);
                b_div = ($urandom_range(0, 3) == 0);
                held_div = b_div;
            end
            step($urandom_range(0, 99) == 0, b_mr, v_irt, v_rs, v_rt, b_urt, b_bt, b_ms, b_div);
        end

        // Saturation: continuous load-use stall from a fresh reset.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65534; i++) step(0, 1, 9, 9, 0, 0, 0, 0, 0);
        idle();
        chk("sat_fffe", {16'd0, stall_cnt}, 32'h0000FFFE);
        for (int i = 0; i < 3; i++) step(0, 1, 9, 9, 0, 0, 0, 0, 0);
        idle();
        chk("sat_ffff", {16'd0, stall_cnt}, 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
